// File: rtl/parking_gate_controller_pkg.sv
// ---------------------------------------------------------------------------
// parking_gate_controller_pkg
// Shared definitions for the parking gate controller: lane FSM state
// encoding, clock-of-day constants and a barrier decode helper.
// ---------------------------------------------------------------------------
package parking_gate_controller_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DECIDE,
    ST_OPEN,
    ST_CROSS,
    ST_CLEAR,
    ST_REPORT,
    ST_REJECT,
    ST_WAIT_CLEAR
  } lane_state_e;

  localparam int MINUTES_PER_HOUR = 60;
  localparam int HOURS_PER_DAY    = 24;

  // The barrier is raised only while a car is being let through.
  function automatic logic barrier_up(input lane_state_e s);
    return (s == ST_OPEN) || (s == ST_CROSS) || (s == ST_CLEAR);
  endfunction

endpackage

// File: rtl/parking_gate_controller_gate_lane_fsm.sv
// ---------------------------------------------------------------------------
// gate_lane_fsm
// One gate lane: synchronises and debounces the two loop detectors (A outer,
// B inner) and the university-card level, then tracks a car through the
// barrier and emits a fixed-width event pulse once it has fully crossed.
//
// Optional build macro: GATE_TIMEOUT_EN -- adds a stall timer that closes
// the barrier after TIMEOUT_CYCLES without a state change in OPEN, CROSS or
// CLEAR. Without it the lane waits indefinitely.
//
// Ports:
//   clk, rst_n    system clock, asynchronous active-low reset
//   i_loop_a/b    raw loop detector levels
//   i_card_uni    raw university-card level
//   i_uni_space   university space available (used when CHECK_SPACE=1)
//   i_space       general space available (used when CHECK_SPACE=1)
//   o_event       car-passed pulse, PULSE_CYCLES wide
//   o_is_uni      class latched at the last decision
//   o_barrier     barrier open
//   o_rejected    one-cycle strobe when entry is refused
// ---------------------------------------------------------------------------
module gate_lane_fsm
  import parking_gate_controller_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int PULSE_CYCLES    = 2,
  parameter int TIMEOUT_CYCLES  = 1000,
  parameter bit CHECK_SPACE     = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_loop_a,
  input  logic i_loop_b,
  input  logic i_card_uni,
  input  logic i_uni_space,
  input  logic i_space,
  output logic o_event,
  output logic o_is_uni,
  output logic o_barrier,
  output logic o_rejected
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int PW = $clog2(PULSE_CYCLES) + 1;

  // Bit 0 = loop A, bit 1 = loop B, bit 2 = card.
  logic [2:0] w_raw;
  logic [2:0] w_db;

  assign w_raw = {i_card_uni, i_loop_b, i_loop_a};

  // Sync + debounce: the debounced level follows the synchronised level
  // only after it has disagreed for DEBOUNCE_CYCLES consecutive cycles.
  for (genvar gi = 0; gi < 3; gi++) begin : g_input
    logic          r_s1;
    logic          r_s2;
    logic          r_db;
    logic [DW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_s1  <= 1'b0;
        r_s2  <= 1'b0;
        r_db  <= 1'b0;
        r_cnt <= '0;
      end else begin
        r_s1 <= w_raw[gi];
        r_s2 <= r_s1;
        if (r_s2 == r_db) begin
          r_cnt <= '0;
        end else if (r_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
          r_db  <= r_s2;
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end

    assign w_db[gi] = r_db;
  end

  logic w_a;
  logic w_b;
  logic w_card;
  assign w_a    = w_db[0];
  assign w_b    = w_db[1];
  assign w_card = w_db[2];

  lane_state_e   r_state;
  lane_state_e   w_state_next;
  logic          r_a_prev;
  logic          r_is_uni;
  logic [PW-1:0] r_pulse_cnt;
  logic          w_a_rise;
  logic          w_permit;
  logic          w_timeout;

  assign w_a_rise = w_a & ~r_a_prev;
  // Exit lane never consults occupancy.
  assign w_permit = CHECK_SPACE ? (w_card ? i_uni_space : i_space) : 1'b1;

`ifdef GATE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TW-1:0] r_to_cnt;

  // Counts cycles spent in the current barrier-up state; any state change
  // restarts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_to_cnt <= '0;
    end else if (!barrier_up(r_state) || (w_state_next != r_state)) begin
      r_to_cnt <= '0;
    end else begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

  assign w_timeout = barrier_up(r_state) && (r_to_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_a_prev    <= 1'b0;
      r_is_uni    <= 1'b0;
      r_pulse_cnt <= '0;
    end else begin
      r_state  <= w_state_next;
      r_a_prev <= w_a;
      if (r_state == ST_DECIDE) begin
        r_is_uni <= w_card;
      end
      if (r_state == ST_REPORT) begin
        r_pulse_cnt <= r_pulse_cnt + 1'b1;
      end else begin
        r_pulse_cnt <= '0;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    o_event      = 1'b0;
    o_rejected   = 1'b0;
    o_barrier    = barrier_up(r_state);
    o_is_uni     = r_is_uni;

    case (r_state)
      ST_IDLE: begin
        // An A rise with B already occupied is a car in the wrong place.
        if (w_a_rise && !w_b) w_state_next = ST_DECIDE;
      end
      ST_DECIDE: begin
        w_state_next = w_permit ? ST_OPEN : ST_REJECT;
      end
      ST_OPEN: begin
        if (w_a && w_b)        w_state_next = ST_CROSS;
        else if (!w_a && !w_b) w_state_next = ST_IDLE;
      end
      ST_CROSS: begin
        if (!w_a && w_b)       w_state_next = ST_CLEAR;
        else if (w_a && !w_b)  w_state_next = ST_OPEN;
      end
      ST_CLEAR: begin
        if (!w_b)              w_state_next = ST_REPORT;
        else if (w_a)          w_state_next = ST_CROSS;
      end
      ST_REPORT: begin
        o_event = 1'b1;
        if (r_pulse_cnt == PW'(PULSE_CYCLES - 1)) w_state_next = ST_IDLE;
      end
      ST_REJECT: begin
        o_rejected   = 1'b1;
        w_state_next = ST_WAIT_CLEAR;
      end
      ST_WAIT_CLEAR: begin
        if (!w_a && !w_b) w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase

    if (w_timeout) w_state_next = ST_WAIT_CLEAR;
  end

endmodule

// File: rtl/parking_gate_controller.sv
// ---------------------------------------------------------------------------
// parking_gate_controller
// Two independent gate lanes (entry checks occupancy, exit always opens)
// plus an hour-of-day counter advanced by a one-cycle minute strobe.
//
// Optional build macro: GATE_TIMEOUT_EN -- enables the per-lane stall
// timeout (TIMEOUT_CYCLES) that closes a barrier left open without progress.
//
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   min_tick                           one-cycle minute strobe
//   entry_loop_a/b, exit_loop_a/b      raw loop levels (A outer, B inner)
//   entry_card_uni, exit_card_uni      raw university-card levels
//   uni_is_vacated_space               university space available
//   is_vacated_space                   general space available
//   car_entered, car_exited            event pulses (counted on falling edge)
//   is_uni_car_entered/exited          class of the last decided car
//   entry/exit_barrier_open            barrier drives
//   entry_rejected                     one-cycle refusal strobe
//   hour                               hour of day 0..23
// ---------------------------------------------------------------------------
module parking_gate_controller
  import parking_gate_controller_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int PULSE_CYCLES    = 2,
  parameter int TIMEOUT_CYCLES  = 1000,
  parameter int HOUR_INIT       = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       min_tick,
  input  logic       entry_loop_a,
  input  logic       entry_loop_b,
  input  logic       exit_loop_a,
  input  logic       exit_loop_b,
  input  logic       entry_card_uni,
  input  logic       exit_card_uni,
  input  logic       uni_is_vacated_space,
  input  logic       is_vacated_space,
  output logic       car_entered,
  output logic       is_uni_car_entered,
  output logic       car_exited,
  output logic       is_uni_car_exited,
  output logic       entry_barrier_open,
  output logic       exit_barrier_open,
  output logic       entry_rejected,
  output logic [4:0] hour
);

  logic w_entry_rejected;
  logic w_exit_rejected;

  gate_lane_fsm #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .PULSE_CYCLES    (PULSE_CYCLES),
    .TIMEOUT_CYCLES  (TIMEOUT_CYCLES),
    .CHECK_SPACE     (1'b1)
  ) u_entry_lane (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_loop_a    (entry_loop_a),
    .i_loop_b    (entry_loop_b),
    .i_card_uni  (entry_card_uni),
    .i_uni_space (uni_is_vacated_space),
    .i_space     (is_vacated_space),
    .o_event     (car_entered),
    .o_is_uni    (is_uni_car_entered),
    .o_barrier   (entry_barrier_open),
    .o_rejected  (w_entry_rejected)
  );

  gate_lane_fsm #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .PULSE_CYCLES    (PULSE_CYCLES),
    .TIMEOUT_CYCLES  (TIMEOUT_CYCLES),
    .CHECK_SPACE     (1'b0)
  ) u_exit_lane (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_loop_a    (exit_loop_a),
    .i_loop_b    (exit_loop_b),
    .i_card_uni  (exit_card_uni),
    .i_uni_space (uni_is_vacated_space),
    .i_space     (is_vacated_space),
    .o_event     (car_exited),
    .o_is_uni    (is_uni_car_exited),
    .o_barrier   (exit_barrier_open),
    .o_rejected  (w_exit_rejected)
  );

  // The exit lane is always permitted so its refusal strobe is constant 0;
  // merging it keeps the output a plain OR of both lanes.
  assign entry_rejected = w_entry_rejected | w_exit_rejected;

  logic [5:0] r_min_cnt;
  logic [4:0] r_hour;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_min_cnt <= '0;
      r_hour    <= 5'(HOUR_INIT);
    end else if (min_tick) begin
      if (r_min_cnt == 6'(MINUTES_PER_HOUR - 1)) begin
        r_min_cnt <= '0;
        r_hour    <= (r_hour == 5'(HOURS_PER_DAY - 1)) ? 5'd0 : r_hour + 5'd1;
      end else begin
        r_min_cnt <= r_min_cnt + 6'd1;
      end
    end
  end

  assign hour = r_hour;

endmodule

// File: tb/tb_parking_gate_controller.sv
module tb_parking_gate_controller;

`ifdef GATE_TIMEOUT_EN
  localparam int TO_CYC = 50;
`else
  localparam int TO_CYC = 1000;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       min_tick = 1'b0;
  logic       entry_loop_a = 1'b0, entry_loop_b = 1'b0;
  logic       exit_loop_a = 1'b0, exit_loop_b = 1'b0;
  logic       entry_card_uni = 1'b0, exit_card_uni = 1'b0;
  logic       uni_is_vacated_space = 1'b0, is_vacated_space = 1'b0;
  logic       car_entered, is_uni_car_entered, car_exited, is_uni_car_exited;
  logic       entry_barrier_open, exit_barrier_open, entry_rejected;
  logic [4:0] hour;

  parking_gate_controller #(
    .DEBOUNCE_CYCLES (4),
    .PULSE_CYCLES    (2),
    .TIMEOUT_CYCLES  (TO_CYC),
    .HOUR_INIT       (8)
  ) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .min_tick             (min_tick),
    .entry_loop_a         (entry_loop_a),
    .entry_loop_b         (entry_loop_b),
    .exit_loop_a          (exit_loop_a),
    .exit_loop_b          (exit_loop_b),
    .entry_card_uni       (entry_card_uni),
    .exit_card_uni        (exit_card_uni),
    .uni_is_vacated_space (uni_is_vacated_space),
    .is_vacated_space     (is_vacated_space),
    .car_entered          (car_entered),
    .is_uni_car_entered   (is_uni_car_entered),
    .car_exited           (car_exited),
    .is_uni_car_exited    (is_uni_car_exited),
    .entry_barrier_open   (entry_barrier_open),
    .exit_barrier_open    (exit_barrier_open),
    .entry_rejected       (entry_rejected),
    .hour                 (hour)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    bit uni;
    int width;
  } exp_t;

  exp_t q_ent[$];
  exp_t q_ext[$];
  exp_t q_rej[$];

  int ent_w = 0, ext_w = 0, rej_w = 0;
  int ent_fall_cyc = -1, ext_fall_cyc = -1;

  task automatic check(input string name, input int got, input int req);
    total++;
    if (got != req) begin
      bad++;
      $display("FAIL %s got=%0d required=%0d", name, got, req);
    end else begin
      $display("ok   %s = %0d", name, got);
    end
  endtask

  task automatic push(input int lane, input bit uni, input int width);
    exp_t e;
    e.uni   = uni;
    e.width = width;
    if (lane == 0)      q_ent.push_back(e);
    else if (lane == 1) q_ext.push_back(e);
    else                q_rej.push_back(e);
  endtask

  // Scoreboard monitor: an event is complete at its falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (car_entered) ent_w++;
    else if (ent_w != 0) begin
      ent_fall_cyc = cyc;
      if (q_ent.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_car_entered got width=%0d required none", ent_w);
      end else begin
        e = q_ent.pop_front();
        check("car_entered_width", ent_w, e.width);
        check("is_uni_car_entered_at_fall", int'(is_uni_car_entered), int'(e.uni));
      end
      ent_w = 0;
    end
    if (car_exited) ext_w++;
    else if (ext_w != 0) begin
      ext_fall_cyc = cyc;
      if (q_ext.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_car_exited got width=%0d required none", ext_w);
      end else begin
        e = q_ext.pop_front();
        check("car_exited_width", ext_w, e.width);
        check("is_uni_car_exited_at_fall", int'(is_uni_car_exited), int'(e.uni));
      end
      ext_w = 0;
    end
    if (entry_rejected) rej_w++;
    else if (rej_w != 0) begin
      if (q_rej.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_entry_rejected got width=%0d required none", rej_w);
      end else begin
        e = q_rej.pop_front();
        check("entry_rejected_width", rej_w, e.width);
      end
      rej_w = 0;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Applies four loop patterns (bit0=A, bit1=B), each held `hold` cycles,
  // to the selected lanes; returns barrier levels at the end of each phase.
  task automatic drive_seq(input logic [1:0] p0, input logic [1:0] p1,
                           input logic [1:0] p2, input logic [1:0] p3,
                           input bit ent, input bit ext, input int hold,
                           output logic [3:0] ent_bar, output logic [3:0] ext_bar);
    logic [1:0] pats [4];
    pats[0] = p0; pats[1] = p1; pats[2] = p2; pats[3] = p3;
    for (int i = 0; i < 4; i++) begin
      if (ent) begin entry_loop_a = pats[i][0]; entry_loop_b = pats[i][1]; end
      if (ext) begin exit_loop_a  = pats[i][0]; exit_loop_b  = pats[i][1]; end
      step(hold);
      ent_bar[i] = entry_barrier_open;
      ext_bar[i] = exit_barrier_open;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] eb, xb;
    int n;

    // Reset state
    step(3);
    check("reset_car_entered", int'(car_entered), 0);
    check("reset_entry_barrier", int'(entry_barrier_open), 0);
    check("reset_exit_barrier", int'(exit_barrier_open), 0);
    check("reset_entry_rejected", int'(entry_rejected), 0);
    check("reset_is_uni_entered", int'(is_uni_car_entered), 0);
    check("reset_hour", int'(hour), 8);
    rst_n = 1'b1;
    step(2);

    // University car enters with university space available
    entry_card_uni = 1'b1; uni_is_vacated_space = 1'b1; is_vacated_space = 1'b0;
    step(10);
    push(0, 1'b1, 2);
    drive_seq(2'b01, 2'b11, 2'b10, 2'b00, 1'b1, 1'b0, 10, eb, xb);
    check("uni_entry_barrier_phases", int'(eb), 4'b0111);
    check("uni_entry_is_uni_after", int'(is_uni_car_entered), 1);

    // Visitor with no general space: refused, no event
    entry_card_uni = 1'b0; is_vacated_space = 1'b0;
    step(10);
    push(2, 1'b0, 1);
    drive_seq(2'b01, 2'b11, 2'b10, 2'b00, 1'b1, 1'b0, 10, eb, xb);
    check("reject_barrier_phases", int'(eb), 4'b0000);
    check("reject_is_uni_updated", int'(is_uni_car_entered), 0);

    // Back-out: OPEN -> CROSS -> OPEN -> IDLE, no event
    is_vacated_space = 1'b1;
    step(10);
    drive_seq(2'b01, 2'b11, 2'b01, 2'b00, 1'b1, 1'b0, 10, eb, xb);
    check("backout_barrier_phases", int'(eb), 4'b0111);

    // Simultaneous entry (visitor) and exit (university)
    exit_card_uni = 1'b1;
    step(10);
    ent_fall_cyc = -1; ext_fall_cyc = -1;
    push(0, 1'b0, 2);
    push(1, 1'b1, 2);
    drive_seq(2'b01, 2'b11, 2'b10, 2'b00, 1'b1, 1'b1, 10, eb, xb);
    check("simul_entry_barrier", int'(eb), 4'b0111);
    check("simul_exit_barrier", int'(xb), 4'b0111);
    check("simul_entry_fell", int'(ent_fall_cyc >= 0), 1);
    check("simul_same_fall_cycle", ent_fall_cyc - ext_fall_cyc, 0);

    // 3-cycle glitch on A: no decision (would otherwise be refused)
    is_vacated_space = 1'b0;
    step(10);
    entry_loop_a = 1'b1;
    step(3);
    entry_loop_a = 1'b0;
    step(15);
    check("glitch_barrier", int'(entry_barrier_open), 0);

    // Hour counter from reset
    rst_n = 1'b0; step(2); rst_n = 1'b1; step(1);
    for (int i = 0; i < 130; i++) begin
      min_tick = 1'b1; step(1);
    end
    min_tick = 1'b0; step(1);
    check("hour_after_130", int'(hour), 10);
    for (int i = 0; i < 960; i++) begin
      min_tick = 1'b1; step(1);
    end
    min_tick = 1'b0; step(1);
    check("hour_after_wrap", int'(hour), 2);

    // Reset during REPORT: event forced low, counted downstream as 1-wide
    entry_card_uni = 1'b1; uni_is_vacated_space = 1'b1;
    step(10);
    push(0, 1'b0, 1);
    entry_loop_a = 1'b1; step(10);
    entry_loop_b = 1'b1; step(10);
    entry_loop_a = 1'b0; step(10);
    entry_loop_b = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!car_entered && n < 30);
    check("report_reached", int'(car_entered), 1);
    #1 rst_n = 1'b0;
    #1;
    check("rst_report_car_entered", int'(car_entered), 0);
    check("rst_report_is_uni", int'(is_uni_car_entered), 0);
    check("rst_report_barrier", int'(entry_barrier_open), 0);
    check("rst_report_hour", int'(hour), 8);
    step(2);
    rst_n = 1'b1;
    step(2);

`ifdef GATE_TIMEOUT_EN
    // Stuck in CROSS: barrier drops on timeout, no event
    entry_card_uni = 1'b0; is_vacated_space = 1'b1;
    step(10);
    entry_loop_a = 1'b1; step(10);
    entry_loop_b = 1'b1; step(10);
    check("timeout_barrier_before", int'(entry_barrier_open), 1);
    n = 0;
    while (entry_barrier_open && n < 200) begin
      step(1);
      n++;
    end
    check("timeout_drop_in_window", int'(n >= 40 && n <= 55), 1);
    entry_loop_a = 1'b0; entry_loop_b = 1'b0;
    step(15);
    check("timeout_barrier_after", int'(entry_barrier_open), 0);
`else
    // Stuck in CROSS: lane waits indefinitely, then completes normally
    entry_card_uni = 1'b0; is_vacated_space = 1'b1;
    step(10);
    push(0, 1'b0, 2);
    entry_loop_a = 1'b1; step(10);
    entry_loop_b = 1'b1; step(120);
    check("no_timeout_barrier_held", int'(entry_barrier_open), 1);
    entry_loop_a = 1'b0; step(10);
    entry_loop_b = 1'b0; step(15);
    check("no_timeout_barrier_after", int'(entry_barrier_open), 0);
`endif

    step(5);
    check("pending_entry_events", q_ent.size(), 0);
    check("pending_exit_events", q_ext.size(), 0);
    check("pending_rejects", q_rej.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
